rggen_external_wb_master: RTL and testbench

Wishbone classic master that terminates the external-register request bus of the register block. It accepts one request (valid/access/address/data/strobe, held until ready) and runs it as a single Wishbone cycle. It returns read data and status on the same bus, with an optional no-response timeout. It sits directly downstream of the external-register stage and drives an external Wishbone slave, for example a peripheral register window.

---
 rtl/rggen_external_wb_master.sv | 168 ++++++++++++++++
 tb/tb_rggen_external_wb_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_external_wb_master.sv
// Wishbone classic master for the external-register request bus: one request becomes one Wishbone cycle.
// Optional no-response abort is enabled by defining RGGEN_EXT_WB_TIMEOUT_EN.
module rggen_external_wb_master #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_external_valid,
  input  logic [1:0]               i_external_access,
  input  logic [ADDRESS_WIDTH-1:0] i_external_address,
  input  logic [BUS_WIDTH-1:0]     i_external_data,
  input  logic [BUS_WIDTH/8-1:0]   i_external_strobe,
  output logic                     o_external_ready,
  output logic [1:0]               o_external_status,
  output logic [BUS_WIDTH-1:0]     o_external_data,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [ADDRESS_WIDTH-1:0] o_wb_adr,
  output logic [BUS_WIDTH-1:0]     o_wb_dat,
  output logic [BUS_WIDTH/8-1:0]   o_wb_sel,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  input  logic [BUS_WIDTH-1:0]     i_wb_dat
);
  localparam int STRB_WIDTH = BUS_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     cyc_q, cyc_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] adr_q, adr_d;
  logic [BUS_WIDTH-1:0]     dat_q, dat_d;
  logic [STRB_WIDTH-1:0]    sel_q, sel_d;
  logic                     ready_q, ready_d;
  logic [1:0]               status_q, status_d;
  logic [BUS_WIDTH-1:0]     rdata_q, rdata_d;
  logic                     timeout;
  logic                     unused_access;

  // Only bit0 (write) of the access code matters to a Wishbone slave.
  assign unused_access = i_external_access[1];

`ifdef RGGEN_EXT_WB_TIMEOUT_EN
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT_CYCLES);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // cnt_q counts silent BUS cycles already elapsed; the current one is the last allowed when it hits CNT_LAST.
  assign timeout = (cnt_q >= CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != BUS) begin
      cnt_d = '0;
    end else if (!(i_wb_ack || i_wb_err) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    ready_d  = 1'b0;
    status_d = status_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (i_external_valid) begin
          we_d    = i_external_access[0];
          adr_d   = i_external_address;
          dat_d   = i_external_data;
          sel_d   = i_external_strobe;
          cyc_d   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        // err beats ack, and any termination beats the timeout in the same cycle.
        if (i_wb_err) begin
          status_d = 2'b10;
          rdata_d  = '0;
          cyc_d    = 1'b0;
          ready_d  = 1'b1;
          state_d  = RESP;
        end else if (i_wb_ack) begin
          status_d = 2'b00;
          rdata_d  = we_q ? '0 : i_wb_dat;
          cyc_d    = 1'b0;
          ready_d  = 1'b1;
          state_d  = RESP;
        end else if (timeout) begin
          status_d = 2'b11;
          rdata_d  = '0;
          cyc_d    = 1'b0;
          ready_d  = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      ready_q  <= 1'b0;
      status_q <= 2'b00;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      ready_q  <= ready_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
    end
  end

  assign o_wb_cyc          = cyc_q;
  assign o_wb_stb          = cyc_q;
  assign o_wb_we           = we_q;
  assign o_wb_adr          = adr_q;
  assign o_wb_dat          = dat_q;
  assign o_wb_sel          = sel_q;
  assign o_external_ready  = ready_q;
  assign o_external_status = status_q;
  assign o_external_data   = rdata_q;

endmodule

// File: tb/tb_rggen_external_wb_master.sv
// Randomized bench for rggen_external_wb_master: a per-request timeline model drives the expectations.
// Timeout cases run only when RGGEN_EXT_WB_TIMEOUT_EN is defined.
module tb_rggen_external_wb_master;
  localparam int AW = 8;
  localparam int BW = 32;
  localparam int SW = 4;
  localparam int T  = 4;
`ifdef RGGEN_EXT_WB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [1:0]    access;
  logic [AW-1:0] addr;
  logic [BW-1:0] wdata;
  logic [SW-1:0] strobe;
  logic          ready;
  logic [1:0]    status;
  logic [BW-1:0] edata;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_adr;
  logic [BW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel;
  logic          wb_ack, wb_err;
  logic [BW-1:0] wb_dat_i;

  always #5 clk = ~clk;

  rggen_external_wb_master #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (BW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_external_valid  (valid),
    .i_external_access (access),
    .i_external_address(addr),
    .i_external_data   (wdata),
    .i_external_strobe (strobe),
    .o_external_ready  (ready),
    .o_external_status (status),
    .o_external_data   (edata),
    .o_wb_cyc          (wb_cyc),
    .o_wb_stb          (wb_stb),
    .o_wb_we           (wb_we),
    .o_wb_adr          (wb_adr),
    .o_wb_dat          (wb_dat_o),
    .o_wb_sel          (wb_sel),
    .i_wb_ack          (wb_ack),
    .i_wb_err          (wb_err),
    .i_wb_dat          (wb_dat_i)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Expected outputs for the current cycle, set by the driver just after each edge.
  bit          chk_en = 1'b0;
  bit          exp_cyc, exp_ready, exp_we;
  logic [7:0]  exp_adr;
  logic [31:0] exp_dat, exp_data;
  logic [3:0]  exp_sel;
  logic [1:0]  exp_status;

  // Observations used by the literal checks.
  int          cyc_count = 0;
  int          wb_starts = 0;
  int          ready_pulses = 0;
  int          last_ready_cycle = 0;
  logic [1:0]  last_status;
  logic [31:0] last_data;
  logic        last_we;
  logic [7:0]  last_adr;
  logic [3:0]  last_sel;
  logic        prev_cyc = 1'b0;

  always @(posedge clk) cyc_count++;

  always @(negedge clk) begin
    if (chk_en) begin
      check("wb_cyc", 32'(wb_cyc), 32'(exp_cyc));
      check("wb_stb", 32'(wb_stb), 32'(exp_cyc));
      check("ready", 32'(ready), 32'(exp_ready));
      if (exp_cyc) begin
        check("wb_we", 32'(wb_we), 32'(exp_we));
        check("wb_adr", 32'(wb_adr), 32'(exp_adr));
        check("wb_dat", wb_dat_o, exp_dat);
        check("wb_sel", 32'(wb_sel), 32'(exp_sel));
      end
      if (exp_ready) begin
        check("status", 32'(status), 32'(exp_status));
        check("rdata", edata, exp_data);
      end
    end
    if (ready) begin
      ready_pulses++;
      last_ready_cycle = cyc_count;
      last_status = status;
      last_data = edata;
    end
    if (wb_cyc && !prev_cyc) wb_starts++;
    if (wb_cyc) begin
      last_we = wb_we;
      last_adr = wb_adr;
      last_sel = wb_sel;
    end
    prev_cyc = wb_cyc;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // resp: BUS cycle (1-based) in which the slave answers, 0 = never.
  // kind: 0 ack, 1 err, 2 ack+err.
  task automatic predict(input bit we, input int resp, input int kind, input logic [31:0] rd,
                         output int term, output logic [1:0] st, output logic [31:0] d);
    if (resp != 0 && (!TO_EN || resp <= T)) begin
      term = resp;
      if (kind != 0) begin
        st = 2'b10;
        d = 32'h0;
      end else begin
        st = 2'b00;
        d = we ? 32'h0 : rd;
      end
    end else begin
      term = T;
      st = 2'b11;
      d = 32'h0;
    end
  endtask

  int txn_issued = 0;
  int c0 = 0;

  task automatic run_txn(input bit we, input logic [7:0] a, input logic [31:0] wd, input logic [3:0] sel,
                         input int resp, input int kind, input logic [31:0] rd);
    int term;
    logic [1:0] st;
    logic [31:0] d;
    predict(we, resp, kind, rd, term, st, d);
    // Request cycle: still IDLE, stray slave signals must be ignored.
    c0 = cyc_count;
    txn_issued++;
    valid = 1'b1;
    access = {1'($urandom_range(0, 1)), we};
    addr = a;
    wdata = wd;
    strobe = sel;
    wb_ack = 1'($urandom_range(0, 1));
    wb_err = 1'($urandom_range(0, 1));
    wb_dat_i = $urandom;
    exp_cyc = 1'b0;
    exp_ready = 1'b0;
    step();
    for (int n = 1; n <= term; n++) begin
      exp_cyc = 1'b1;
      exp_ready = 1'b0;
      exp_we = we;
      exp_adr = a;
      exp_dat = wd;
      exp_sel = sel;
      // Upstream inputs may change once accepted; the bus must hold the captured values.
      addr = 8'($urandom);
      wdata = $urandom;
      strobe = 4'($urandom);
      wb_ack = (n == resp) && (kind != 1);
      wb_err = (n == resp) && (kind != 0);
      wb_dat_i = (n == resp) ? rd : $urandom;
      step();
    end
    exp_cyc = 1'b0;
    exp_ready = 1'b1;
    exp_status = st;
    exp_data = d;
    wb_ack = 1'($urandom_range(0, 1));
    wb_err = 1'($urandom_range(0, 1));
    step();
    valid = 1'b0;
    exp_ready = 1'b0;
    step();
    wb_ack = 1'b0;
    wb_err = 1'b0;
    $display("txn %0d we=%0b adr=%h resp=%0d kind=%0d exp_status=%b exp_data=%h", txn_issued, we, a, resp,
             kind, st, d);
  endtask

  int pulses0, starts0, resp, kind;

  initial begin
    rst = 1'b1;
    valid = 1'b0;
    access = 2'b00;
    addr = '0;
    wdata = '0;
    strobe = '0;
    wb_ack = 1'b0;
    wb_err = 1'b0;
    wb_dat_i = '0;
    repeat (3) step();
    check("rst_cyc", 32'(wb_cyc), 0);
    check("rst_stb", 32'(wb_stb), 0);
    check("rst_we", 32'(wb_we), 0);
    check("rst_adr", 32'(wb_adr), 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_sel", 32'(wb_sel), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_status", 32'(status), 0);
    check("rst_edata", edata, 0);
    rst = 1'b0;
    exp_cyc = 1'b0;
    exp_ready = 1'b0;
    chk_en = 1'b1;
    step();

    // Minimum-latency read.
    pulses0 = ready_pulses;
    starts0 = wb_starts;
    run_txn(1'b0, 8'h20, 32'h0, 4'hF, 1, 0, 32'hDEADBEEF);
    check("lat_read", 32'(last_ready_cycle - c0), 2);
    check("lit_status_read", 32'(last_status), 0);
    check("lit_data_read", last_data, 32'hDEADBEEF);
    check("lit_we_read", 32'(last_we), 0);
    check("one_pulse_read", 32'(ready_pulses - pulses0), 1);
    check("one_cycle_read", 32'(wb_starts - starts0), 1);

    // Write, ack in third BUS cycle.
    pulses0 = ready_pulses;
    starts0 = wb_starts;
    run_txn(1'b1, 8'h14, 32'h12345678, 4'b0101, 3, 0, 32'hCAFEF00D);
    check("lat_write", 32'(last_ready_cycle - c0), 4);
    check("lit_adr_write", 32'(last_adr), 32'h14);
    check("lit_sel_write", 32'(last_sel), 32'h5);
    check("lit_we_write", 32'(last_we), 1);
    check("lit_data_write", last_data, 0);
    check("one_pulse_write", 32'(ready_pulses - pulses0), 1);
    check("one_cycle_write", 32'(wb_starts - starts0), 1);

    // ack and err together.
    run_txn(1'b0, 8'h08, 32'h0, 4'hF, 2, 2, 32'h55AA55AA);
    check("lit_status_err", 32'(last_status), 2);
    check("lit_data_err", last_data, 0);

`ifdef RGGEN_EXT_WB_TIMEOUT_EN
    run_txn(1'b0, 8'h30, 32'h0, 4'hF, 0, 0, 32'h11111111);
    check("lat_timeout", 32'(last_ready_cycle - c0), T + 1);
    check("lit_status_timeout", 32'(last_status), 3);
    check("lit_data_timeout", last_data, 0);
    run_txn(1'b0, 8'h34, 32'h0, 4'hF, T, 0, 32'h22222222);
    check("lit_status_lastack", 32'(last_status), 0);
    check("lit_data_lastack", last_data, 32'h22222222);
`endif

    // Reset while in BUS: the request is dropped, no ready appears.
    pulses0 = ready_pulses;
    txn_issued++;
    valid = 1'b1;
    access = 2'b00;
    addr = 8'h44;
    wdata = 32'h0;
    strobe = 4'hF;
    exp_cyc = 1'b0;
    exp_ready = 1'b0;
    step();
    valid = 1'b0;
    exp_cyc = 1'b1;
    exp_we = 1'b0;
    exp_adr = 8'h44;
    exp_dat = 32'h0;
    exp_sel = 4'hF;
    step();
    rst = 1'b1;
    step();
    exp_cyc = 1'b0;
    check("rst_mid_adr", 32'(wb_adr), 0);
    rst = 1'b0;
    step();
    step();
    check("rst_mid_no_ready", 32'(ready_pulses - pulses0), 0);
    run_txn(1'b0, 8'h48, 32'h0, 4'h3, 2, 0, 32'h0BADF00D);
    check("lit_data_after_rst", last_data, 32'h0BADF00D);

    // Randomized requests against the model.
    for (int i = 0; i < 40; i++) begin
      resp = TO_EN ? $urandom_range(0, T + 2) : $urandom_range(1, 6);
      kind = $urandom_range(0, 2);
      run_txn(1'($urandom_range(0, 1)), 8'($urandom), $urandom, 4'($urandom), resp, kind, $urandom);
    end

    check("wb_cycles_total", 32'(wb_starts), 32'(txn_issued));
    check("ready_total", 32'(ready_pulses), 32'(txn_issued - 1));
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
